// File: rtl/q_fixed_pkg.sv
// Shared Q-format definitions for the fixed-point multiplier/divider pair.
// Default format is signed Q15.48 in 64 bits; saturation values are common to both units.
package q_fixed_pkg;

  localparam int Q_WIDTH = 64;
  localparam int Q_FRAC  = 48;

  localparam logic [Q_WIDTH-1:0] SAT_POS = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] SAT_NEG = {1'b1, {(Q_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/q_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder, then trial-subtract.
// Combinational, zero latency; no handshake.
module q_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);

  logic [W:0] r_sh;
  logic [W:0] diff;

  // The stored remainder is always below the divisor, so the result fits back into W bits.
  always_comb begin
    r_sh    = {rem, din};
    diff    = r_sh - {1'b0, divisor};
    q_bit   = (r_sh >= {1'b0, divisor});
    rem_nxt = W'(q_bit ? diff : r_sh);
  end

endmodule

// File: rtl/q_fixed_divider.sv
// Signed Q-format divider, res = (a << FRAC) / b, restoring one bit per cycle, truncate + saturate.
// Latency WIDTH+FRAC+2 cycles from accept (1 cycle for divide-by-zero); one op in flight.
// in_ready only in IDLE; result held in DONE until out_ready, then one bubble back to IDLE.
module q_fixed_divider
  import q_fixed_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             nan,
  output logic             ovf
);

  localparam int DW    = WIDTH + FRAC;
  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);
  localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             nan_q, nan_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [WIDTH-1:0] q_lo;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) without loss.
  always_comb begin
    mag_a = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b = b_q[WIDTH-1] ? -b_q : b_q;
  end

  q_div_step #(.W(WIDTH)) u_step (
    .rem     (rem_q),
    .din     (dvd_q[DW-1]),
    .divisor (mag_b_q),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  // After the last step the dividend register holds the full quotient magnitude.
  always_comb begin
    q_lo    = dvd_q[WIDTH-1:0];
    pos_ovf = |dvd_q[DW-1:WIDTH-1];
    neg_ovf = (|dvd_q[DW-1:WIDTH]) | (dvd_q[WIDTH-1] & (|dvd_q[WIDTH-2:0]));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        mag_b_d = mag_b;
        ovf_d   = 1'b0;
        if (b_q == '0) begin
          nan_d   = 1'b1;
          res_d   = a_q[WIDTH-1] ? SAT_N : SAT_P;
          state_d = ST_DONE;
        end else begin
          nan_d   = 1'b0;
          dvd_d   = {mag_a, {FRAC{1'b0}}};
          rem_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DW-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!sign_q && pos_ovf) begin
          res_d = SAT_P;
          ovf_d = 1'b1;
        end else if (sign_q && neg_ovf) begin
          res_d = SAT_N;
          ovf_d = 1'b1;
        end else begin
          // Negating a zero magnitude yields zero, so a zero quotient is always +0.
          res_d = sign_q ? -q_lo : q_lo;
          ovf_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign nan       = nan_q;
  assign ovf       = ovf_q;

endmodule
